// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the data-processing control sequencer:
// state encoding, ALU no-op code, condition codes and flag bit positions.
package dp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_PCINC   = 3'd4
  } state_e;

  localparam int OP_NOP = 17;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // TST/TEQ/CMP/CMN only set flags and never write a register
  localparam logic [3:0] OPC_CMP_LO = 4'd8;
  localparam logic [3:0] OPC_CMP_HI = 4'd11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic isCompare(input logic [3:0] opc);
    return (opc >= OPC_CMP_LO) && (opc <= OPC_CMP_HI);
  endfunction

endpackage

// File: rtl/dp_cond_check.sv
// Combinational ARM condition-field evaluator against the {N,Z,C,V} flags.
module dp_cond_check
  import dp_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_instr_sequencer.sv
// Multi-cycle control sequencer for one ARM data-processing instruction.
// Outputs are registered from the current state, so they trail the state by one cycle.
module dp_instr_sequencer
  import dp_ctrl_pkg::*;
#(
  parameter int OP_WIDTH    = 5,
  parameter int RSLCT_WIDTH = 20,
  parameter int PC_REG      = 15
) (
  input  logic                   Clk,
  input  logic                   RESET,
  input  logic                   start,
  input  logic [31:0]            IR_in,
  input  logic [3:0]             FLAGS,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal,
  output logic [31:0]            IR,
  output logic [RSLCT_WIDTH-1:0] RSLCT,
  output logic [OP_WIDTH-1:0]    OP,
  output logic                   S,
  output logic                   ALU_OUT,
  output logic                   LOAD,
  output logic                   LOADPC,
  output logic                   IR_CU
);

  state_e                 state_q, state_d;
  logic [31:0]            ir_q, ir_d;
  logic [RSLCT_WIDTH-1:0] rslct_q, rslct_d;
  logic [OP_WIDTH-1:0]    op_q, op_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   illegal_q, illegal_d;
  logic                   illegalPend_q, illegalPend_d;
  logic                   s_q, s_d;
  logic                   aluOut_q, aluOut_d;
  logic                   load_q, load_d;
  logic                   loadPc_q, loadPc_d;
  logic                   irCu_q;

  logic                   condPass;
  logic [3:0]             opcode;
  logic                   isDataProc;
  logic                   cmpOp;
  logic                   rdIsPc;

  assign opcode     = ir_q[24:21];
  assign isDataProc = (ir_q[27:26] == 2'b00);
  assign cmpOp      = isCompare(opcode);
  assign rdIsPc     = (ir_q[15:12] == 4'(PC_REG));

  dp_cond_check u_cond_check (
    .cond_i  (ir_q[31:28]),
    .flags_i (FLAGS),
    .pass_o  (condPass)
  );

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      ir_q          <= '0;
      rslct_q       <= '0;
      op_q          <= OP_WIDTH'(OP_NOP);
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      illegalPend_q <= 1'b0;
      s_q           <= 1'b0;
      aluOut_q      <= 1'b0;
      load_q        <= 1'b0;
      loadPc_q      <= 1'b0;
      irCu_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      rslct_q       <= rslct_d;
      op_q          <= op_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      illegalPend_q <= illegalPend_d;
      s_q           <= s_d;
      aluOut_q      <= aluOut_d;
      load_q        <= load_d;
      loadPc_q      <= loadPc_d;
      irCu_q        <= 1'b1;
    end
  end

  // In IDLE with busy still set, the previous instruction's last strobes are on the
  // outputs; that cycle emits done, and a new start is only taken once busy has dropped.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    rslct_d       = rslct_q;
    busy_d        = busy_q;
    illegalPend_d = illegalPend_q;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    op_d          = OP_WIDTH'(OP_NOP);
    s_d           = 1'b0;
    aluOut_d      = 1'b0;
    load_d        = 1'b0;
    loadPc_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (busy_q) begin
          done_d    = 1'b1;
          illegal_d = illegalPend_q;
          busy_d    = 1'b0;
        end else if (start) begin
          ir_d          = IR_in;
          rslct_d       = RSLCT_WIDTH'({IR_in[15:12], IR_in[11:8], IR_in[3:0],
                                        IR_in[19:16], 4'hF});
          busy_d        = 1'b1;
          illegalPend_d = 1'b0;
          state_d       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!isDataProc) begin
          illegalPend_d = 1'b1;
          state_d       = ST_PCINC;
        end else if (!condPass) begin
          state_d = ST_PCINC;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        op_d     = OP_WIDTH'({1'b0, opcode});
        aluOut_d = 1'b1;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        op_d     = OP_WIDTH'({1'b0, opcode});
        aluOut_d = 1'b1;
        s_d      = ir_q[20];
        if (cmpOp) begin
          s_d     = 1'b1;
          state_d = ST_PCINC;
        end else if (!rdIsPc) begin
          load_d  = 1'b1;
          state_d = ST_PCINC;
        end else begin
          loadPc_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_PCINC: begin
        loadPc_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign IR      = ir_q;
  assign RSLCT   = rslct_q;
  assign OP      = op_q;
  assign S       = s_q;
  assign ALU_OUT = aluOut_q;
  assign LOAD    = load_q;
  assign LOADPC  = loadPc_q;
  assign IR_CU   = irCu_q;

endmodule

// File: tb/tb_dp_instr_sequencer.sv
// Randomised bench for dp_instr_sequencer, checked against a per-instruction
// cycle-trace model derived from the instruction's class and condition outcome.
module tb_dp_instr_sequencer;

  localparam logic [4:0] NOP = 5'd17;

  logic        Clk = 1'b0;
  logic        RESET;
  logic        start;
  logic [31:0] IR_in;
  logic [3:0]  FLAGS;
  logic        busy, done, illegal, S, ALU_OUT, LOAD, LOADPC, IR_CU;
  logic [31:0] IR;
  logic [19:0] RSLCT;
  logic [4:0]  OP;

  int testCount = 0;
  int failCount = 0;

  always #5 Clk = ~Clk;

  dp_instr_sequencer dut (
    .Clk     (Clk),
    .RESET   (RESET),
    .start   (start),
    .IR_in   (IR_in),
    .FLAGS   (FLAGS),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .IR      (IR),
    .RSLCT   (RSLCT),
    .OP      (OP),
    .S       (S),
    .ALU_OUT (ALU_OUT),
    .LOAD    (LOAD),
    .LOADPC  (LOADPC),
    .IR_CU   (IR_CU)
  );

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ctlVec(input logic b, input logic d, input logic il,
                                         input logic [4:0] op, input logic s,
                                         input logic alu, input logic ld, input logic ldpc);
    return {20'b0, b, d, il, op, s, alu, ld, ldpc};
  endfunction

  function automatic logic [31:0] dutCtl();
    return ctlVec(busy, done, illegal, OP, S, ALU_OUT, LOAD, LOADPC);
  endfunction

  // Condition codes come in complementary pairs: even code tests a predicate,
  // odd code tests its negation; 1110 always passes and 1111 never does.
  function automatic logic condPasses(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cond == 4'hE) return 1'b1;
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return cond[0] ? ~base : base;
  endfunction

  // Issues one instruction and checks every cycle until its done pulse.
  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] decodeFlags,
                               input bit holdStart, input int gap);
    logic [31:0] expTrace[$];
    logic [4:0]  opc;
    logic        legal, pass, cmp, pcDest, sBit;
    opc    = {1'b0, instr[24:21]};
    legal  = (instr[27:26] == 2'b00);
    pass   = condPasses(instr[31:28], decodeFlags);
    cmp    = (instr[24:21] >= 4'd8) && (instr[24:21] <= 4'd11);
    pcDest = (instr[15:12] == 4'd15);
    sBit   = instr[20];

    IR_in = instr;
    start = 1'b1;
    @(posedge Clk); #1;
    checkOutput("accept ctl", dutCtl(), ctlVec(1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    checkOutput("IR latch", IR, instr);
    checkOutput("RSLCT", {12'b0, RSLCT},
                {12'b0, instr[15:12], instr[11:8], instr[3:0], instr[19:16], 4'hF});
    FLAGS = decodeFlags;
    start = 1'($urandom_range(0, 1));
    IR_in = $urandom;

    expTrace.push_back(ctlVec(1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    if (!legal || !pass) begin
      expTrace.push_back(ctlVec(1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b1));
      expTrace.push_back(ctlVec(1'b0, 1'b1, ~legal, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    end else if (cmp || !pcDest) begin
      expTrace.push_back(ctlVec(1'b1, 1'b0, 1'b0, opc, 1'b0, 1'b1, 1'b0, 1'b0));
      expTrace.push_back(ctlVec(1'b1, 1'b0, 1'b0, opc, cmp | sBit, 1'b1, ~cmp, 1'b0));
      expTrace.push_back(ctlVec(1'b1, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b1));
      expTrace.push_back(ctlVec(1'b0, 1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      expTrace.push_back(ctlVec(1'b1, 1'b0, 1'b0, opc, 1'b0, 1'b1, 1'b0, 1'b0));
      expTrace.push_back(ctlVec(1'b1, 1'b0, 1'b0, opc, sBit, 1'b1, 1'b0, 1'b1));
      expTrace.push_back(ctlVec(1'b0, 1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    for (int k = 0; k < expTrace.size(); k++) begin
      @(posedge Clk); #1;
      checkOutput($sformatf("ctl %08h edge %0d", instr, k + 1), dutCtl(), expTrace[k]);
      FLAGS = 4'($urandom);
      start = 1'($urandom_range(0, 1));
      IR_in = $urandom;
    end
    checkOutput("IR hold", IR, instr);

    if (holdStart) begin
      start = 1'b1;
    end else begin
      start = 1'b0;
      repeat (gap) begin
        @(posedge Clk); #1;
        checkOutput("idle ctl", dutCtl(), ctlVec(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    RESET = 1'b0;
    start = 1'b0;
    IR_in = '0;
    FLAGS = '0;
    #12;
    checkOutput("reset ctl", dutCtl(), ctlVec(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    checkOutput("reset IR", IR, 32'h0);
    checkOutput("reset RSLCT", {12'b0, RSLCT}, 32'h0);
    checkOutput("reset IR_CU", {31'b0, IR_CU}, 32'h0);
    RESET = 1'b1;
    @(posedge Clk); #1;
    checkOutput("IR_CU up", {31'b0, IR_CU}, 32'h1);
    checkOutput("idle after reset", dutCtl(), ctlVec(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));

    applyStimulus(32'hE0812003, 4'($urandom), 1'b0, 1);
    applyStimulus(32'h00812003, 4'b0000, 1'b0, 1);
    applyStimulus(32'hE1510002, 4'($urandom), 1'b0, 1);
    applyStimulus(32'hE1A0F003, 4'($urandom), 1'b0, 1);
    applyStimulus(32'hE5912000, 4'($urandom), 1'b1, 0);
    applyStimulus(32'hE0812003, 4'($urandom), 1'b0, 2);

    // Asynchronous reset while the write strobe is on the outputs.
    IR_in = 32'hE0812003;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("pre-reset LOAD", {31'b0, LOAD}, 32'h1);
    #2 RESET = 1'b0;
    #1;
    checkOutput("async reset ctl", dutCtl(), ctlVec(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge Clk);
    RESET = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      checkOutput("post-reset idle", dutCtl(), ctlVec(1'b0, 1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    for (int t = 0; t < 150; t++) begin
      r = $urandom;
      if ($urandom_range(0, 4) != 0) r[27:26] = 2'b00;
      if ($urandom_range(0, 3) == 0) r[15:12] = 4'hF;
      if ($urandom_range(0, 3) == 0) r[24:21] = 4'($urandom_range(8, 11));
      applyStimulus(r, 4'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
